// File: rtl/afe_spi_pkg.sv
// Shared constants, types and FSM state encoding for the AFE SPI responder.
// 20-bit frames: 4-bit address followed by 16-bit data, MSB first.
package afe_spi_pkg;

    localparam int FRAME_BITS     = 20;
    localparam int ADDR_BITS      = 4;
    localparam int DATA_BITS      = 16;
    localparam int NUM_REGS       = 1 << ADDR_BITS;
    localparam int READ_EN_BIT    = 0;
    localparam int SOFT_RESET_BIT = 1;
    localparam int CNT_BITS       = $clog2(FRAME_BITS + 1);

    localparam logic [ADDR_BITS-1:0] REG_CTRL_ADDR  = '0;
    localparam logic [CNT_BITS-1:0]  ADDR_DONE_CNT  = CNT_BITS'(ADDR_BITS - 1);
    localparam logic [CNT_BITS-1:0]  FRAME_DONE_CNT = CNT_BITS'(FRAME_BITS - 1);

    typedef logic [ADDR_BITS-1:0]  addr_t;
    typedef logic [DATA_BITS-1:0]  data_t;
    typedef logic [FRAME_BITS-1:0] frame_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        DRAIN
    } state_e;

endpackage

// File: rtl/afe_spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
// Latency SYNC_STAGES clks to dout; edge pulses last one clk; no backpressure.
module afe_spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/afe_spi_responder.sv
// SPI slave writing a 16x16 register file, with optional readback on miso.
// Commit ~SYNC_STAGES+2 clks after the 20th sclk rise; SPI has no backpressure.
module afe_spi_responder
    import afe_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        wr_strobe,
    output logic [3:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_error,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_data
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic edges_unused;

    afe_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(sclk),
        .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    afe_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .reset(reset), .din(cs_n),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall));
    afe_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    assign edges_unused = sclk_lvl | cs_rise | mosi_rise | mosi_fall;

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
    frame_t                shift_q, shift_d;
    data_t                 tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic                  wr_strobe_q, wr_strobe_d;
    addr_t                 wr_addr_q, wr_addr_d;
    data_t                 wr_data_q, wr_data_d;
    logic                  frame_error_q, frame_error_d;
    data_t                 rd_data_q, rd_data_d;
    data_t                 regs_q [NUM_REGS];
    data_t                 regs_d [NUM_REGS];
    frame_t                frame_nxt;
    logic                  read_en;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        wr_strobe_d   = 1'b0;
        wr_addr_d     = '0;
        wr_data_d     = '0;
        frame_error_d = 1'b0;
        regs_d        = regs_q;
        frame_nxt     = {shift_q[FRAME_BITS-2:0], mosi_s};
        read_en       = regs_q[REG_CTRL_ADDR][READ_EN_BIT];

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (sclk_fall && miso_oe_q) begin
                    miso_d = tx_q[DATA_BITS-1];
                    tx_d   = {tx_q[DATA_BITS-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    shift_d   = frame_nxt;
                    bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
                    if (read_en && bit_cnt_q == ADDR_DONE_CNT) begin
                        tx_d      = regs_q[frame_nxt[ADDR_BITS-1:0]];
                        miso_oe_d = 1'b1;
                    end
                    if (bit_cnt_q == FRAME_DONE_CNT) begin
                        state_d = COMMIT;
                        // Strobe is pre-registered so it is valid exactly in COMMIT.
                        if (!read_en || frame_nxt[FRAME_BITS-1 -: ADDR_BITS] == REG_CTRL_ADDR) begin
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = frame_nxt[FRAME_BITS-1 -: ADDR_BITS];
                            wr_data_d   = frame_nxt[DATA_BITS-1:0];
                        end
                    end
                end else if (cs_s) begin
                    state_d       = IDLE;
                    frame_error_d = 1'b1;
                end
            end
            COMMIT: begin
                state_d = DRAIN;
                if (wr_strobe_q) begin
                    if (wr_addr_q == REG_CTRL_ADDR && wr_data_q[SOFT_RESET_BIT]) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            regs_d[i] = '0;
                        end
                    end else begin
                        regs_d[wr_addr_q] = wr_data_q;
                    end
                end
            end
            DRAIN: begin
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cs_s) begin
            miso_oe_d = 1'b0;
            miso_d    = 1'b0;
        end

        // Reading the next-state array forwards a same-clk write to rd_data.
        rd_data_d = regs_d[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tx_q          <= '0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            wr_strobe_q   <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_error_q <= 1'b0;
            rd_data_q     <= '0;
            regs_q        <= '{default: '0};
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            wr_strobe_q   <= wr_strobe_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_error_q <= frame_error_d;
            rd_data_q     <= rd_data_d;
            regs_q        <= regs_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_error = frame_error_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_afe_spi_responder.sv
// Randomized bench for afe_spi_responder against a register-file reference model.
module tb_afe_spi_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic        wr_strobe;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_error;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;

    afe_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_error(frame_error),
        .rd_addr(rd_addr), .rd_data(rd_data));

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] model_regs [16];
    logic [19:0] wr_q [$];
    int          fe_cnt = 0;
    bit          fwd_pend = 1'b0;
    logic [15:0] fwd_val = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fwd_pend) begin
            fwd_val  = rd_data;
            fwd_pend = 1'b0;
        end
        if (wr_strobe) begin
            wr_q.push_back({wr_addr, wr_data});
            fwd_pend = 1'b1;
        end
        if (frame_error) fe_cnt++;
    end

    // Sends nbits sclk periods; miso is sampled at the end of each low phase.
    task automatic send_frame(input logic [19:0] fr, input int nbits, input int rst_at,
                              output logic [15:0] rx, output int oe_cnt);
        rx     = '0;
        oe_cnt = 0;
        @(negedge clk);
        cs_n = 1'b0;
        #80;
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_at) begin
                reset = 1'b1;
                repeat (3) @(negedge clk);
                reset = 1'b0;
            end
            mosi = (k < 20) ? fr[19-k] : 1'($urandom);
            #40;
            if (k < 20 && miso_oe) oe_cnt++;
            if (k >= 4 && k < 20) rx[19-k] = miso;
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
        end
        #40;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic sweep_regs();
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("rd_data[%0d]", i), rd_data, model_regs[i]);
        end
    endtask

    task automatic run_frame(input logic [19:0] fr, input int nbits);
        logic [15:0] rx;
        logic [19:0] w;
        int          oe;
        logic [3:0]  a;
        logic [15:0] d;
        bit          re;
        bit          wr_exp;
        a  = fr[19:16];
        d  = fr[15:0];
        re = model_regs[0][0];
        wr_q.delete();
        fe_cnt  = 0;
        rd_addr = a;
        send_frame(fr, nbits, -1, rx, oe);
        if (nbits < 20) begin
            check("abort_frame_error", fe_cnt, 1);
            check("abort_no_write", wr_q.size(), 0);
        end else begin
            wr_exp = !re || (a == 4'd0);
            check("frame_error_none", fe_cnt, 0);
            check("wr_strobe_count", wr_q.size(), wr_exp ? 1 : 0);
            if (wr_exp && wr_q.size() > 0) begin
                w = wr_q[0];
                check("wr_addr", w[19:16], a);
                check("wr_data", w[15:0], d);
            end
            check("miso_oe_bits", oe, re ? 16 : 0);
            check("miso_word", rx, re ? model_regs[a] : 16'h0);
            if (wr_exp) begin
                if (a == 4'd0 && d[1]) begin
                    for (int i = 0; i < 16; i++) model_regs[i] = '0;
                end else begin
                    model_regs[a] = d;
                end
                check("rd_forward", fwd_val, model_regs[a]);
            end
        end
        sweep_regs();
    endtask

    initial begin
        logic [15:0] rx;
        int          oe;
        int          r;
        int          nb;
        reset   = 1'b1;
        sclk    = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        rd_addr = 4'($urandom);
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        repeat (5) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        run_frame(20'h3_1234, 20);
        run_frame(20'h0_0001, 20);
        run_frame(20'h3_0000, 20);
        run_frame(20'h0_0000, 20);
        run_frame(20'h7_BEEF, 11);
        run_frame(20'h5_ABCD, 24);

        for (int n = 0; n < 12; n++) begin
            r  = $urandom_range(0, 9);
            nb = (r == 0) ? $urandom_range(1, 19) : (r == 1) ? $urandom_range(21, 24) : 20;
            run_frame(20'($urandom), nb);
        end

        run_frame(20'h0_0000, 20);
        for (int a = 1; a < 16; a++) run_frame({4'(a), 16'($urandom)}, 20);
        run_frame(20'h0_0001, 20);
        run_frame(20'h0_0002, 20);
        run_frame(20'h3_1111, 20);

        wr_q.delete();
        fe_cnt = 0;
        send_frame(20'h6_4321, 20, 10, rx, oe);
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        check("midframe_reset_no_write", wr_q.size(), 0);
        check("midframe_reset_no_error", fe_cnt, 0);
        sweep_regs();
        run_frame(20'h9_5A5A, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
